// File: rtl/controlador_de_interrupcao.sv
// Single-level interrupt controller: edge-latched requests, mask, fixed priority
// (lowest index wins) and the irq/inta/service/restore handshake with the PC.
module controlador_de_interrupcao #(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned CAUSE_W = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_IRQ-1:0] i_irq_req,
  input  logic               i_int_enable,
  input  logic               i_mask_we,
  input  logic [NUM_IRQ-1:0] i_mask_in,
  input  logic               i_instr_boundary,
  input  logic               i_reti,
  output logic               o_irq,
  output logic               o_inta,
  output logic [CAUSE_W-1:0] o_cause,
  output logic               o_in_service,
  output logic               o_restore,
  output logic [NUM_IRQ-1:0] o_pending,
  output logic [NUM_IRQ-1:0] o_mask
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PEND    = 3'd1;
  localparam logic [2:0] S_ACK     = 3'd2;
  localparam logic [2:0] S_SERVICE = 3'd3;
  localparam logic [2:0] S_RET     = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_irq_req_q;
  logic [NUM_IRQ-1:0] w_set;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_eligible;
  logic [CAUSE_W-1:0] r_cause;
  logic [CAUSE_W-1:0] w_prio;
  logic               w_take;

  assign w_set      = i_irq_req & ~r_irq_req_q;
  assign w_eligible = i_int_enable ? (r_pending & r_mask) : '0;
  assign w_take     = (r_state == S_PEND) && (w_eligible != '0) && i_instr_boundary;

  // Scan downwards so the lowest eligible index is the last one written.
  always_comb begin
    w_prio = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_prio = CAUSE_W'(i);
    end
  end

  always_comb begin
    w_clr = '0;
    if (r_state == S_ACK) w_clr[r_cause] = 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_eligible != '0) w_state_next = S_PEND;
      S_PEND: begin
        if (w_eligible == '0)      w_state_next = S_IDLE;
        else if (i_instr_boundary) w_state_next = S_ACK;
      end
      S_ACK:     w_state_next = S_SERVICE;
      S_SERVICE: if (i_reti) w_state_next = S_RET;
      S_RET:     w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_mask      <= '0;
      r_irq_req_q <= '0;
      r_cause     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_irq_req_q <= i_irq_req;
      // A fresh edge on the line being acknowledged survives the clear.
      r_pending   <= (r_pending & ~w_clr) | w_set;
      if (i_mask_we) r_mask <= i_mask_in;
      if (w_take) r_cause <= w_prio;
    end
  end

  assign o_irq        = (r_state == S_PEND);
  assign o_inta       = (r_state == S_ACK);
  assign o_in_service = (r_state == S_SERVICE);
  assign o_restore    = (r_state == S_RET);
  assign o_cause      = r_cause;
  assign o_pending    = r_pending;
  assign o_mask       = r_mask;

endmodule
